uart_rx_sequencer: RTL
======================

Name: uart_rx_sequencer

Overview:
- Receive-side controller that sequences the UART Rx deframer datapath.
- Oversamples the serial line and assembles an 11-bit frame into data_parll, then pulses recieved_flag.
- Waits for the deframer's done_flag, checks parity and stop bit, and presents the byte to the consumer on a valid/ready handshake.
- Sits between the baud generator and the host-side Rx interface.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, >= 4.
- DF_TIMEOUT, 4, cycles to wait for done_flag_i before the frame is dropped.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-cycle enable at OVERSAMPLE x baud rate
- rx_serial  input  1  asynchronous serial line, idle high
- parity_type  input  2  00 odd, 01 even, 1x no parity check
- data_parll  output  11  assembled frame to deframer: [0] start, [8:1] data LSB-first, [9] parity, [10] stop
- recieved_flag  output  1  one-cycle pulse, data_parll valid
- start_bit_i, stop_bit_i, parity_bit_i  input  1 each  deframer outputs
- raw_data_i  input  8  deframer data output
- done_flag_i  input  1  deframer completion
- rx_data  output  8  received byte
- rx_valid  output  1  rx_data/error flags valid
- rx_ready  input  1  consumer accepts when rx_valid & rx_ready
- parity_err  output  1  parity mismatch for the held byte
- frame_err  output  1  stop bit or start bit error for the held byte
- overrun  output  1  one-cycle pulse, frame dropped because the holding register was full
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; data_parll 0.
  - recieved_flag, rx_data, rx_valid, parity_err, frame_err, overrun: all 0.
  - Synchronizer flops preset to 1; tick_cnt and bit_cnt 0.
- rx_serial passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- IDLE:
  - On baud_tick with rx_s=0: tick_cnt<=0, go START.
- START:
  - Count baud_ticks. On the tick where tick_cnt==OVERSAMPLE/2-1, sample rx_s.
  - rx_s=0: shift 0 into the frame, bit_cnt<=1, tick_cnt<=0, go DATA.
  - rx_s=1: false start; go IDLE, no flags raised.
- DATA:
  - On the tick where tick_cnt==OVERSAMPLE-1, sample rx_s, tick_cnt<=0, bit_cnt++.
  - Shift right, inserting at [10], so the first received bit lands in [0].
  - When bit_cnt reaches 11, load data_parll and go FRAME.
- FRAME:
  - Single cycle; recieved_flag=1; data_parll held stable until the next frame loads. Go CHECK.
- CHECK:
  - Wait for done_flag_i=1; the deframer outputs are sampled in that cycle.
  - If DF_TIMEOUT cycles elapse without done_flag_i: frame dropped, go IDLE, nothing published.
  - Errors:
    - fe = (stop_bit_i!=1) | (start_bit_i!=0).
    - pe = (parity_type==00) ? ~^{raw_data_i,parity_bit_i} : (parity_type==01) ? ^{raw_data_i,parity_bit_i} : 0.
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data<=raw_data_i, parity_err<=pe, frame_err<=fe, rx_valid<=1.
  - Otherwise: overrun=1 for one cycle; the new frame is discarded and the held data is unchanged.
  - Go IDLE. Minimum turnaround is one cycle, so a start edge on the next tick is caught.
- Handshake:
  - rx_valid falls the cycle after rx_valid & rx_ready unless it is reloaded in that cycle.
  - rx_data and the error flags stay stable while rx_valid=1 and rx_ready=0.
- baud_tick absent: the FSM holds its state indefinitely; the CHECK timeout counts clock cycles, not ticks.
- parity_type is sampled only in CHECK; changing it mid-frame affects only the current check.
- reset_n asserted mid-frame aborts immediately; the partial frame is lost and no recieved_flag is issued.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- When defined:
  - Adds output break_det (1 bit, reset 0).
  - A frame with data_parll==11'h000 sets break_det=1 instead of being published (rx_valid unaffected, no overrun).
  - The FSM then waits in BREAK state until rx_s=1 on a baud_tick, clears break_det, and returns to IDLE.
- When undefined:
  - No port, no BREAK state.
  - An all-zero frame is handled as a normal byte 0x00 with frame_err=1.

Test Plan:
- Odd parity (parity_type=00), send 0xA5 with parity 1, stop 1; deframer model returns fields with done_flag_i the cycle after recieved_flag -> data_parll=11'b1_1_10100101_0, recieved_flag one pulse, rx_valid=1, rx_data=0xA5, parity_err=0, frame_err=0.
- Even parity, send 0x3C with parity 1 -> rx_data=0x3C, parity_err=1; same with parity_type=10 -> parity_err=0.
- Low glitch of 4 ticks on rx_serial in IDLE -> returns to IDLE, no recieved_flag, busy drops after the mid-bit sample.
- rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the second CHECK; raise rx_ready -> rx_valid falls next cycle.
- Stop bit 0 on 0x55 -> frame_err=1; deframer model withholds done_flag_i -> after 4 cycles the FSM is IDLE with rx_valid unchanged.
- Assert reset_n=0 after bit 5 of a frame -> all outputs 0 asynchronously; the next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_sequencer_if.sv
// Host-side receive handshake for uart_rx_sequencer: held byte, error flags, valid/ready and overrun pulse.
`timescale 1ns/1ps
interface uart_rx_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART Rx sequencer: oversampled frame capture, deframer handshake, parity/stop checks, host valid/ready.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
`timescale 1ns/1ps
module uart_rx_sequencer #(
    parameter int OVERSAMPLE = 16,
    parameter int DF_TIMEOUT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        baud_tick,
    input  logic        rx_serial,
    input  logic [1:0]  parity_type,
    output logic [10:0] data_parll,
    output logic        recieved_flag,
    input  logic        start_bit_i,
    input  logic        stop_bit_i,
    input  logic        parity_bit_i,
    input  logic [7:0]  raw_data_i,
    input  logic        done_flag_i,
    uart_rx_sequencer_if.master host,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic        break_det,
`endif
    output logic        busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int DF_W   = $clog2(DF_TIMEOUT + 1);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [DF_W-1:0]   DF_LAST   = DF_W'(DF_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_FRAME,
        S_CHECK
`ifdef UART_RX_BREAK_DETECT_EN
        , S_BREAK
`endif
    } state_t;

    state_t              state_reg;
    logic [1:0]          sync_reg;
    logic                rx_s;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [3:0]          bit_cnt_reg;
    logic [DF_W-1:0]     df_cnt_reg;
    logic [10:0]         shift_reg;
    logic                pe_next;
    logic                fe_next;

    assign rx_s = sync_reg[1];
    assign busy = (state_reg != S_IDLE);

    // Error flags from the deframer fields, evaluated in the cycle done_flag_i is seen.
    assign fe_next = ~stop_bit_i | start_bit_i;
    always_comb begin
        pe_next = 1'b0;
        case (parity_type)
            2'b00:   pe_next = ~^{raw_data_i, parity_bit_i};
            2'b01:   pe_next = ^{raw_data_i, parity_bit_i};
            default: pe_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg        <= 2'b11;
            state_reg       <= S_IDLE;
            tick_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            df_cnt_reg      <= '0;
            shift_reg       <= '0;
            data_parll      <= '0;
            recieved_flag   <= 1'b0;
            host.rx_data    <= '0;
            host.rx_valid   <= 1'b0;
            host.parity_err <= 1'b0;
            host.frame_err  <= 1'b0;
            host.overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_det       <= 1'b0;
`endif
        end else begin
            sync_reg      <= {sync_reg[0], rx_serial};
            recieved_flag <= 1'b0;
            host.overrun  <= 1'b0;
            if (host.rx_valid && host.rx_ready)
                host.rx_valid <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (baud_tick && !rx_s) begin
                        tick_cnt_reg <= '0;
                        state_reg    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if (tick_cnt_reg == MID_TICK) begin
                            if (!rx_s) begin
                                shift_reg    <= {1'b0, shift_reg[10:1]};
                                bit_cnt_reg  <= 4'd1;
                                tick_cnt_reg <= '0;
                                state_reg    <= S_DATA;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt_reg == LAST_TICK) begin
                            tick_cnt_reg <= '0;
                            shift_reg    <= {rx_s, shift_reg[10:1]};
                            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                            // Eleventh sample completes the frame; publish it directly.
                            if (bit_cnt_reg == 4'd10) begin
                                data_parll    <= {rx_s, shift_reg[10:1]};
                                recieved_flag <= 1'b1;
                                state_reg     <= S_FRAME;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + 1'b1;
                        end
                    end
                end
                S_FRAME: begin
                    df_cnt_reg <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (data_parll == 11'h000) begin
                        break_det <= 1'b1;
                        state_reg <= S_BREAK;
                    end else begin
                        state_reg <= S_CHECK;
                    end
`else
                    state_reg <= S_CHECK;
`endif
                end
                S_CHECK: begin
                    if (done_flag_i) begin
                        if (!host.rx_valid || host.rx_ready) begin
                            host.rx_data    <= raw_data_i;
                            host.parity_err <= pe_next;
                            host.frame_err  <= fe_next;
                            host.rx_valid   <= 1'b1;
                        end else begin
                            host.overrun <= 1'b1;
                        end
                        state_reg <= S_IDLE;
                    end else if (df_cnt_reg == DF_LAST) begin
                        state_reg <= S_IDLE;
                    end else begin
                        df_cnt_reg <= df_cnt_reg + 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                S_BREAK: begin
                    if (baud_tick && rx_s) begin
                        break_det <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
